// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state encoding and PC step.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_RECOVER = 2'd1,
      ST_HALT    = 2'd2
   } state_t;

   localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge Clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: same-cycle combinational PC source select, flushes and stall control;
// RUN/RECOVER/HALT FSM with a recovery down-counter and a saturating mispredict counter.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int               ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int               FLUSH_CYCLES = 1,
   parameter int               CNT_W        = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] PC,
   input  logic              BtbHit,
   input  logic [ADDR_W-1:0] BtbTarget,
   input  logic              JumpValid,
   input  logic [ADDR_W-1:0] JumpTarget,
   input  logic              ExResolveValid,
   input  logic              ExMispredict,
   input  logic [ADDR_W-1:0] ExCorrectPC,
   input  logic              HazardStall,
   input  logic              Halt,
   output logic [ADDR_W-1:0] NextPC,
   output logic              PCWrite_Disable,
   output logic              IF_Flush,
   output logic              ID_Flush,
   output logic [CNT_W-1:0]  MispredictCount,
   output logic [1:0]        State
);

   localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

   state_t            state, state_next;
   logic [3:0]        rcnt, rcnt_next;
   logic              mispredict;
   logic [ADDR_W-1:0] pc_plus4;

   assign mispredict = ExResolveValid & ExMispredict;
   assign pc_plus4   = PC + ADDR_W'(PC_INCR);
   assign State      = state;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_RUN;
         rcnt  <= '0;
      end else begin
         state <= state_next;
         rcnt  <= rcnt_next;
      end
   end

   always_comb begin
      NextPC          = pc_plus4;
      PCWrite_Disable = 1'b0;
      IF_Flush        = 1'b0;
      ID_Flush        = 1'b0;
      state_next      = state;
      rcnt_next       = rcnt;

      if (Reset) begin
         NextPC = RESET_PC;
      end else if (mispredict) begin
         // Redirect wins in every state; a halt seen here was on the wrong path.
         NextPC     = ExCorrectPC;
         IF_Flush   = 1'b1;
         ID_Flush   = 1'b1;
         state_next = ST_RECOVER;
         rcnt_next  = FLUSH_LD;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (Halt) begin
                  PCWrite_Disable = 1'b1;
                  IF_Flush        = 1'b1;
                  state_next      = ST_HALT;
               end else if (HazardStall) begin
                  PCWrite_Disable = 1'b1;
               end else if (JumpValid) begin
                  NextPC   = JumpTarget;
                  IF_Flush = 1'b1;
               end else if (BtbHit) begin
                  NextPC = BtbTarget;
               end
            end
            ST_RECOVER: begin
               // ID holds a bubble, so jump/stall/halt from it are stale.
               if (BtbHit) begin
                  NextPC = BtbTarget;
               end
               rcnt_next = rcnt - 1'b1;
               if (rcnt == 4'd1) begin
                  state_next = ST_RUN;
               end
            end
            ST_HALT: begin
               PCWrite_Disable = 1'b1;
               NextPC          = PC;
            end
            default: begin
               state_next = ST_RUN;
            end
         endcase
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_mispredict_cnt (
      .Clk  (Clk),
      .clr  (Reset),
      .inc  (mispredict),
      .count(MispredictCount)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (default and small-counter/long-recover) against a rule-level model.
module tb_pc_sequencer;

   logic        Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Reset;
   logic [31:0] PC, BtbTarget, JumpTarget, ExCorrectPC;
   logic        BtbHit, JumpValid, ExResolveValid, ExMispredict, HazardStall, Halt;

   logic [31:0] npc_a, npc_b;
   logic        wd_a, wd_b, iff_a, iff_b, idf_a, idf_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;
   logic [1:0]  st_a, st_b;

   int checks = 0;
   int errors = 0;

   // Model: mode 0=running, 1=recovering, 2=halted; left = recovery cycles remaining.
   int          m_mode[2] = '{0, 0};
   int          m_left[2] = '{0, 0};
   int          m_cnt[2]  = '{0, 0};
   int          fc[2]     = '{1, 3};
   int          cmax[2]   = '{65535, 3};
   logic [31:0] rpc[2]    = '{32'h0, 32'h1000};

   pc_sequencer dut_a (
      .Clk(Clk), .Reset(Reset), .PC(PC), .BtbHit(BtbHit), .BtbTarget(BtbTarget),
      .JumpValid(JumpValid), .JumpTarget(JumpTarget), .ExResolveValid(ExResolveValid),
      .ExMispredict(ExMispredict), .ExCorrectPC(ExCorrectPC), .HazardStall(HazardStall),
      .Halt(Halt), .NextPC(npc_a), .PCWrite_Disable(wd_a), .IF_Flush(iff_a),
      .ID_Flush(idf_a), .MispredictCount(cnt_a), .State(st_a)
   );

   pc_sequencer #(
      .RESET_PC(32'h1000), .FLUSH_CYCLES(3), .CNT_W(2)
   ) dut_b (
      .Clk(Clk), .Reset(Reset), .PC(PC), .BtbHit(BtbHit), .BtbTarget(BtbTarget),
      .JumpValid(JumpValid), .JumpTarget(JumpTarget), .ExResolveValid(ExResolveValid),
      .ExMispredict(ExMispredict), .ExCorrectPC(ExCorrectPC), .HazardStall(HazardStall),
      .Halt(Halt), .NextPC(npc_b), .PCWrite_Disable(wd_b), .IF_Flush(iff_b),
      .ID_Flush(idf_b), .MispredictCount(cnt_b), .State(st_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      Reset = 1'b0; BtbHit = 1'b0; JumpValid = 1'b0; ExResolveValid = 1'b0;
      ExMispredict = 1'b0; HazardStall = 1'b0; Halt = 1'b0;
   endtask

   // Inputs are driven 1 time unit after the rising edge; outputs are checked at the falling edge.
   task automatic step();
      logic        misp, e_wd, e_iff, e_idf, chk_npc;
      logic [31:0] e_npc, o_npc, o_cnt;
      logic        o_wd, o_iff, o_idf;
      logic [1:0]  o_st;
      int          nmode, nleft, ncnt;
      string       nm;
      #4;
      misp = ExResolveValid && ExMispredict;
      for (int i = 0; i < 2; i++) begin
         e_npc = PC + 32'd4; e_wd = 1'b0; e_iff = 1'b0; e_idf = 1'b0; chk_npc = 1'b1;
         nmode = m_mode[i]; nleft = m_left[i]; ncnt = m_cnt[i];
         if (Reset) begin
            e_npc = rpc[i]; nmode = 0; nleft = 0; ncnt = 0;
         end else if (misp) begin
            e_npc = ExCorrectPC; e_iff = 1'b1; e_idf = 1'b1;
            nmode = 1; nleft = fc[i];
            ncnt = (m_cnt[i] < cmax[i]) ? m_cnt[i] + 1 : cmax[i];
         end else if (m_mode[i] == 2) begin
            e_wd = 1'b1; e_npc = PC;
         end else if (m_mode[i] == 1) begin
            if (BtbHit) e_npc = BtbTarget;
            nleft = m_left[i] - 1;
            if (nleft == 0) nmode = 0;
         end else if (Halt) begin
            e_wd = 1'b1; e_iff = 1'b1; chk_npc = 1'b0; nmode = 2;
         end else if (HazardStall) begin
            e_wd = 1'b1; chk_npc = 1'b0;
         end else if (JumpValid) begin
            e_npc = JumpTarget; e_iff = 1'b1;
         end else if (BtbHit) begin
            e_npc = BtbTarget;
         end
         nm    = (i == 0) ? "a" : "b";
         o_npc = (i == 0) ? npc_a : npc_b;
         o_wd  = (i == 0) ? wd_a  : wd_b;
         o_iff = (i == 0) ? iff_a : iff_b;
         o_idf = (i == 0) ? idf_a : idf_b;
         o_st  = (i == 0) ? st_a  : st_b;
         o_cnt = (i == 0) ? 32'(cnt_a) : 32'(cnt_b);
         if (chk_npc) check({nm, "_next_pc"}, o_npc, e_npc);
         check({nm, "_pcwrite_disable"}, 32'(o_wd), 32'(e_wd));
         check({nm, "_if_flush"}, 32'(o_iff), 32'(e_iff));
         check({nm, "_id_flush"}, 32'(o_idf), 32'(e_idf));
         check({nm, "_state"}, 32'(o_st), 32'(m_mode[i]));
         check({nm, "_mispredict_count"}, o_cnt, 32'(m_cnt[i]));
         m_mode[i] = nmode; m_left[i] = nleft; m_cnt[i] = ncnt;
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      idle();
      Reset = 1'b1; PC = 32'h40; BtbTarget = '0; JumpTarget = '0; ExCorrectPC = '0;
      @(posedge Clk);
      #1;

      // Reset held for two cycles
      step();
      step();

      // Jump outranks BTB hit
      idle(); PC = 32'h100; BtbHit = 1'b1; BtbTarget = 32'h200;
      JumpValid = 1'b1; JumpTarget = 32'h300;
      step();

      // Mispredict outranks stall and halt; then RECOVER ignores the jump
      ExResolveValid = 1'b1; ExMispredict = 1'b1; ExCorrectPC = 32'h80;
      HazardStall = 1'b1; Halt = 1'b1;
      step();
      idle(); JumpValid = 1'b1; PC = 32'h80;
      step();
      check("a_count_after_redirect", 32'(cnt_a), 32'd1);
      idle(); PC = 32'h84; BtbHit = 1'b1; BtbTarget = 32'h500;
      step();
      step();

      // Unqualified ExMispredict is ignored
      idle(); ExMispredict = 1'b1; PC = 32'h10;
      step();

      // Load-use stall for three cycles, then release
      idle(); PC = 32'h24; HazardStall = 1'b1;
      repeat (3) step();
      HazardStall = 1'b0;
      step();

      // PC+4 wraps at the top of the address space
      idle(); PC = 32'hFFFF_FFFC;
      step();

      // Five back-to-back mispredicts saturate the 2-bit counter
      for (int k = 0; k < 5; k++) begin
         idle(); ExResolveValid = 1'b1; ExMispredict = 1'b1; ExCorrectPC = 32'h1000 + 32'(k * 16);
         step();
      end
      idle();
      check("b_count_saturated", 32'(cnt_b), 32'd3);
      repeat (3) step();

      // Halt, hold for ten cycles, then Reset out of HALT
      idle(); PC = 32'h2000; Halt = 1'b1;
      step();
      Halt = 1'b0; JumpValid = 1'b1; HazardStall = 1'b1;
      for (int k = 0; k < 10; k++) begin
         PC = 32'h2000 + 32'(k * 4);
         step();
      end
      idle(); Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();

      // Mispredict while halted leads to RECOVER
      idle(); Halt = 1'b1; step();
      idle(); ExResolveValid = 1'b1; ExMispredict = 1'b1; ExCorrectPC = 32'h3000;
      step();
      idle(); repeat (4) step();

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         Reset          = ($urandom_range(0, 99) < 3);
         PC             = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         BtbHit         = 1'($urandom_range(0, 1));
         BtbTarget      = $urandom;
         JumpValid      = ($urandom_range(0, 2) == 0);
         JumpTarget     = $urandom;
         ExResolveValid = ($urandom_range(0, 3) == 0);
         ExMispredict   = 1'($urandom_range(0, 1));
         ExCorrectPC    = $urandom;
         HazardStall    = ($urandom_range(0, 3) == 0);
         Halt           = ($urandom_range(0, 29) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
